neopixel_driver: RTL
====================

// Module: neopixel_driver
// PURPOSE
//  Consumer end of the NeoPixel load/send handshake. Holds a GRB colour register file for
//  NUM_PIXELS pixels, accepts per-channel level writes from the producer FSM, and on
//  send_it serialises the whole strip as a WS2812 one-wire NRZ stream on neo_data,
//  followed by a latch (low) gap. Sits between the pattern producer and the LED pin.
// PARAMETERS
//  NUM_PIXELS    5     pixels in strip (1..8; pixel_index is 3 bits)
//  T0H_CYCLES    18    high time of a '0' bit (0.36 us @ 50 MHz)
//  T1H_CYCLES    35    high time of a '1' bit (0.70 us)
//  TBIT_CYCLES   63    total bit period, high + low (1.26 us)
//  LATCH_CYCLES  2500  post-frame low gap (50 us)
// PORTS
//  clock          in   1  system clock
//  reset          in   1  asynchronous, active-high
//  pixel_index    in   3  pixel to write (0 = first pixel on wire)
//  color_index    in   2  channel: 00 red, 01 green, 10 blue, 11 reserved
//  color_level    in   8  channel level to write
//  load_color     in   1  write strobe, qualified by ready_to_load
//  send_it        in   1  start-frame strobe, qualified by ready_to_send
//  neo_data       out  1  WS2812 serial data, registered
//  ready_to_load  out  1  register file writable (state IDLE)
//  ready_to_send  out  1  frame may be started (state IDLE)
//  begin_send     out  1  1-cycle pulse: first cycle neo_data is high for frame
//  done_send      out  1  1-cycle pulse: last bit period finished, latch gap begins
//  done_wait      out  1  1-cycle pulse: latch gap finished, back to IDLE
// BEHAVIOUR
//  - Reset: state IDLE, all colour regs 0, neo_data 0, begin/done pulses 0, counters 0;
//    ready_to_load = ready_to_send = 1 (combinational decode of IDLE).
//  - States: IDLE -> BIT_HIGH -> BIT_LOW -> (BIT_HIGH | LATCH) -> IDLE.
//  - IDLE, load_color=1: reg[pixel_index][color_index] <= color_level at clock edge.
//    pixel_index >= NUM_PIXELS or color_index = 11: write silently dropped.
//  - IDLE, send_it=1 at edge k: enter BIT_HIGH; neo_data=1 and begin_send=1 in cycle k+1.
//  - load_color and send_it together in IDLE: write is committed first and IS in the frame.
//  - Outside IDLE, load_color and send_it are ignored (no queuing, regs unchanged).
//  - Bit order: pixel 0 first; per pixel green[7:0], red[7:0], blue[7:0], MSB first.
//  - Per bit: neo_data high T1H_CYCLES ('1') or T0H_CYCLES ('0'), then low until
//    TBIT_CYCLES elapsed; consecutive bits back-to-back, no gaps.
//  - After bit 24*NUM_PIXELS-1 low phase: done_send pulse, enter LATCH, neo_data 0 for
//    LATCH_CYCLES cycles, then done_wait pulse in final LATCH cycle; IDLE next cycle.
//  - Frame: begin_send at k+1, done_send at k+1+24*NUM_PIXELS*TBIT_CYCLES,
//    done_wait LATCH_CYCLES later (defaults: 7560, 2500).
//  - Counters: cycle counter width $clog2(max(TBIT,LATCH)+1), bit 0..23 wrap, pixel
//    0..NUM_PIXELS-1; all cleared on frame start; no wrap beyond last pixel.
//  - Reset mid-frame: neo_data drops to 0 asynchronously, regs cleared, IDLE, no done_*.
//  - Colour regs hold value across frames unless rewritten.
// CONFIGURATION
//  NEOPIXEL_AUTO_CLEAR_EN defined: on the done_wait cycle all colour regs clear to 0, so
//    each frame shows only values loaded since the previous frame.
//  Undefined: colour regs persist across frames (default).
// TESTING
//  1 reset, send_it -> 120 bits each 18 high/45 low, done_send at +7560, done_wait +2500.
//  2 load px0 green=8'h18, send -> bits 3,4 of frame high 35 cycles, all others 18.
//  3 load px4 blue=8'hFF same cycle as send_it -> last 8 bits of frame are '1'.
//  4 load px5 and color_index 11, plus load px1 during send -> frame identical to all-zero.
//  5 reset asserted at bit 50 -> neo_data 0 same cycle; next frame all-zero from bit 0.
//  6 AUTO_CLEAR_EN: load px2 red=8'h80, send twice -> 2nd frame all zero; undefined: repeats.

Source files
------------

// File: rtl/neopixel_driver_if.sv
// Producer <-> NeoPixel driver handshake: colour writes, frame start, status pulses
// and the serial LED line.
interface neopixel_driver_if;
    logic [2:0] pixel_index;
    logic [1:0] color_index;
    logic [7:0] color_level;
    logic       load_color;
    logic       send_it;
    logic       neo_data;
    logic       ready_to_load;
    logic       ready_to_send;
    logic       begin_send;
    logic       done_send;
    logic       done_wait;

    modport master (
        output pixel_index, color_index, color_level, load_color, send_it,
        input  neo_data, ready_to_load, ready_to_send, begin_send, done_send, done_wait
    );

    modport slave (
        input  pixel_index, color_index, color_level, load_color, send_it,
        output neo_data, ready_to_load, ready_to_send, begin_send, done_send, done_wait
    );
endinterface

// File: rtl/neopixel_driver.sv
// WS2812 strip driver: GRB register file plus NRZ serialiser with latch gap.
// Optional NEOPIXEL_AUTO_CLEAR_EN: colour regs clear when the latch gap finishes.
module neopixel_driver #(
    parameter int NUM_PIXELS   = 5,
    parameter int T0H_CYCLES   = 18,
    parameter int T1H_CYCLES   = 35,
    parameter int TBIT_CYCLES  = 63,
    parameter int LATCH_CYCLES = 2500
) (
    input  logic              clock,
    input  logic              reset,
    neopixel_driver_if.slave  bus
);
    localparam int CMAX = (TBIT_CYCLES > LATCH_CYCLES) ? TBIT_CYCLES : LATCH_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] T0H_END   = CW'(T0H_CYCLES - 1);
    localparam logic [CW-1:0] T1H_END   = CW'(T1H_CYCLES - 1);
    localparam logic [CW-1:0] TBIT_END  = CW'(TBIT_CYCLES - 1);
    localparam logic [CW-1:0] LATCH_END = CW'(LATCH_CYCLES - 1);
    localparam logic [2:0]    LAST_PIX  = 3'(NUM_PIXELS - 1);
    localparam logic [3:0]    NPIX      = 4'(NUM_PIXELS);

    typedef enum logic [1:0] {IDLE, BIT_HIGH, BIT_LOW, LATCH} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [4:0]      bit_cnt;
    logic [2:0]      pix_cnt;
    logic            neo, begin_p, done_s, done_w;
    // channel index: 0 red, 1 green, 2 blue
    logic [NUM_PIXELS-1:0][2:0][7:0] regs;

    logic            idle, wr_ok, cur_bit, last_bit;
    logic [7:0]      cur_chan;
    logic [CW-1:0]   high_end;

    always_comb begin
        idle     = (state == IDLE);
        wr_ok    = idle && bus.load_color && ({1'b0, bus.pixel_index} < NPIX)
                   && (bus.color_index != 2'b11);
        // wire order per pixel is green, red, blue
        if (bit_cnt < 5'd8)       cur_chan = regs[pix_cnt][1];
        else if (bit_cnt < 5'd16) cur_chan = regs[pix_cnt][0];
        else                      cur_chan = regs[pix_cnt][2];
        cur_bit  = cur_chan[~bit_cnt[2:0]];
        high_end = cur_bit ? T1H_END : T0H_END;
        last_bit = (bit_cnt == 5'd23) && (pix_cnt == LAST_PIX);
    end

    assign bus.ready_to_load = idle;
    assign bus.ready_to_send = idle;
    assign bus.neo_data      = neo;
    assign bus.begin_send    = begin_p;
    assign bus.done_send     = done_s;
    assign bus.done_wait     = done_w;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            regs <= '0;
        end else begin
            if (wr_ok) regs[bus.pixel_index][bus.color_index] <= bus.color_level;
`ifdef NEOPIXEL_AUTO_CLEAR_EN
            if (state == LATCH && done_w) regs <= '0;
`endif
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            pix_cnt <= '0;
            neo     <= 1'b0;
            begin_p <= 1'b0;
            done_s  <= 1'b0;
            done_w  <= 1'b0;
        end else begin
            begin_p <= 1'b0;
            done_s  <= 1'b0;
            case (state)
                IDLE: if (bus.send_it) begin
                    state   <= BIT_HIGH;
                    neo     <= 1'b1;
                    begin_p <= 1'b1;
                    cnt     <= '0;
                    bit_cnt <= '0;
                    pix_cnt <= '0;
                end
                BIT_HIGH: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == high_end) begin
                        state <= BIT_LOW;
                        neo   <= 1'b0;
                    end
                end
                BIT_LOW: begin
                    if (cnt != TBIT_END) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                        if (last_bit) begin
                            state  <= LATCH;
                            done_s <= 1'b1;
                        end else begin
                            state <= BIT_HIGH;
                            neo   <= 1'b1;
                            if (bit_cnt == 5'd23) begin
                                bit_cnt <= '0;
                                pix_cnt <= pix_cnt + 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                end
                LATCH: begin
                    // done_wait lands LATCH_CYCLES after done_send; IDLE the cycle after
                    if (done_w) begin
                        done_w <= 1'b0;
                        cnt    <= '0;
                        state  <= IDLE;
                    end else if (cnt == LATCH_END) begin
                        done_w <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
